// File: rtl/cast_pe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cast_pe_pkg : shared types, fixed-point defaults and saturating adder    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package cast_pe_pkg;

  typedef enum logic {
    ACC_CHAIN = 1'b0,
    ACC_LOCAL = 1'b1
  } acc_mode_e;

  localparam int INPUT_WIDTH_DEF      = 16;
  localparam int INPUT_INT_WIDTH_DEF  = 8;
  localparam int WEIGHT_WIDTH_DEF     = 8;
  localparam int WEIGHT_INT_WIDTH_DEF = 2;

  // Wide enough to hold any supported psum plus one guard bit.
  localparam int SUM_MAX_W = 64;

  // Operands arrive sign-extended to SUM_MAX_W; w is the target psum width.
  // Returns {ovf, sum}; sum is clamped when sat is set, raw otherwise.
  function automatic logic [SUM_MAX_W:0] sat_add(
    input logic signed [SUM_MAX_W-1:0] a,
    input logic signed [SUM_MAX_W-1:0] b,
    input int unsigned                 w,
    input logic                        sat
  );
    logic signed [SUM_MAX_W-1:0] s;
    logic signed [SUM_MAX_W-1:0] one;
    logic signed [SUM_MAX_W-1:0] vmax;
    logic signed [SUM_MAX_W-1:0] vmin;
    logic                        ovf;
    one  = {{(SUM_MAX_W-1){1'b0}}, 1'b1};
    vmax = (one << (w - 1)) - one;
    vmin = ~vmax;
    s    = a + b;
    ovf  = (s > vmax) || (s < vmin);
    if (ovf && sat) begin
      s = (s > vmax) ? vmax : vmin;
    end
    return {ovf, s};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_point_mult.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_point_mult : full-width signed fixed-point multiplier              |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module fixed_point_mult #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 8
) (
  input  logic [A_WIDTH-1:0]         i_a,
  input  logic [B_WIDTH-1:0]         i_b,
  output logic [A_WIDTH+B_WIDTH-1:0] o_p
);
  localparam int PW = A_WIDTH + B_WIDTH;

  logic [PW-1:0] w_a;
  logic [PW-1:0] w_b;

  // Sign-extend both to the product width; the low PW bits are then exact.
  assign w_a = {{B_WIDTH{i_a[A_WIDTH-1]}}, i_a};
  assign w_b = {{A_WIDTH{i_b[B_WIDTH-1]}}, i_b};
  assign o_p = w_a * w_b;

endmodule
`default_nettype wire

// File: rtl/ws_weight_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws_weight_bank : double-buffered (shadow/active) weight register file    |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module ws_weight_bank #(
  parameter int NUM_W = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_valid,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_swap,
  input  logic [AW-1:0]    i_rd_sel,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_shadow [NUM_W];
  logic [WIDTH-1:0] r_active [NUM_W];
  logic [WIDTH-1:0] w_rd_data;

  // Swap reads the shadow before this cycle's write lands (non-blocking).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_W; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else if (i_clr) begin
      for (int k = 0; k < NUM_W; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_W; k++) begin
        if (i_swap) begin
          r_active[k] <= r_shadow[k];
        end
        if (i_wr_valid && (i_wr_addr == AW'(k))) begin
          r_shadow[k] <= i_wr_data;
        end
      end
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_W; k++) begin
      if (i_rd_sel == AW'(k)) begin
        w_rd_data = r_active[k];
      end
    end
  end

  assign o_rd_data = w_rd_data;

endmodule
`default_nettype wire

// File: rtl/ws_pe_dbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws_pe_dbuf : weight-stationary PE, double-buffered weights, 2-stage MAC  |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module ws_pe_dbuf
  import cast_pe_pkg::*;
#(
  parameter int INPUT_WIDTH      = 16,
  parameter int INPUT_INT_WIDTH  = 8,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int WEIGHT_INT_WIDTH = 2,
  parameter int PSUM_WIDTH       = INPUT_WIDTH + WEIGHT_WIDTH,
  parameter int NUM_W            = 4,
  parameter int SATURATE         = 1,
  localparam int AW              = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iclr,
  input  logic                    wclr,
  input  logic                    wload_i_valid,
  input  logic [AW-1:0]           wload_i_addr,
  input  logic [WEIGHT_WIDTH-1:0] weight_i_data,
  input  logic                    wswap_i,
  input  logic [AW-1:0]           wsel_i,
  input  logic                    acc_mode_i,
  input  logic                    iload_i_valid,
  input  logic [INPUT_WIDTH-1:0]  if_i_data,
  input  logic                    psum_i_valid,
  input  logic [PSUM_WIDTH-1:0]   psum_i_data,
  output logic                    iload_o_valid,
  output logic [INPUT_WIDTH-1:0]  if_o_data,
  output logic                    wload_o_valid,
  output logic [AW-1:0]           wload_o_addr,
  output logic [WEIGHT_WIDTH-1:0] weight_o_data,
  output logic                    psum_o_valid,
  output logic [PSUM_WIDTH-1:0]   psum_o_data,
  output logic                    ovf_o
);
  localparam int PW = INPUT_WIDTH + WEIGHT_WIDTH;

  if ((PSUM_WIDTH >= SUM_MAX_W) || (PW >= SUM_MAX_W) || (NUM_W < 1) ||
      (INPUT_INT_WIDTH > INPUT_WIDTH) || (WEIGHT_INT_WIDTH > WEIGHT_WIDTH)) begin : g_param_check
    $error("ws_pe_dbuf: unsupported parameter set");
  end

  logic [WEIGHT_WIDTH-1:0]         w_sel_weight;
  logic [PW-1:0]                   w_prod;
  logic [PSUM_WIDTH-1:0]           w_addend;
  logic [SUM_MAX_W-1:0]            w_addend_ext;
  logic [SUM_MAX_W-1:0]            w_prod_ext;
  logic [SUM_MAX_W:0]              w_add_res;
  logic                            w_ovf;
  logic [SUM_MAX_W-PSUM_WIDTH-1:0] w_unused_hi;
  logic [PSUM_WIDTH-1:0]           w_sum;

  logic                    r_wfwd_valid;
  logic [AW-1:0]           r_wfwd_addr;
  logic [WEIGHT_WIDTH-1:0] r_wfwd_data;

  logic                    r_s1_valid;
  logic [INPUT_WIDTH-1:0]  r_s1_if;
  logic [WEIGHT_WIDTH-1:0] r_s1_w;
  acc_mode_e               r_s1_mode;

  logic                    r_psum_valid;
  logic [PSUM_WIDTH-1:0]   r_psum;
  logic                    r_ovf;

  ws_weight_bank #(
    .NUM_W (NUM_W),
    .WIDTH (WEIGHT_WIDTH),
    .AW    (AW)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (wclr),
    .i_wr_valid (wload_i_valid),
    .i_wr_addr  (wload_i_addr),
    .i_wr_data  (weight_i_data),
    .i_swap     (wswap_i),
    .i_rd_sel   (wsel_i),
    .o_rd_data  (w_sel_weight)
  );

  // Weight daisy chain: forwarded every cycle, including out-of-range slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wfwd_valid <= 1'b0;
      r_wfwd_addr  <= '0;
      r_wfwd_data  <= '0;
    end else if (wclr) begin
      r_wfwd_valid <= 1'b0;
      r_wfwd_addr  <= '0;
      r_wfwd_data  <= '0;
    end else begin
      r_wfwd_valid <= wload_i_valid;
      r_wfwd_addr  <= wload_i_addr;
      r_wfwd_data  <= weight_i_data;
    end
  end

  // S1 samples the active bank at the same edge a swap takes effect,
  // so an op coincident with a swap sees the old weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_if    <= '0;
      r_s1_w     <= '0;
      r_s1_mode  <= ACC_CHAIN;
    end else if (iclr) begin
      r_s1_valid <= 1'b0;
      r_s1_if    <= '0;
      r_s1_w     <= '0;
      r_s1_mode  <= ACC_CHAIN;
    end else begin
      r_s1_valid <= iload_i_valid;
      if (iload_i_valid) begin
        r_s1_if   <= if_i_data;
        r_s1_w    <= w_sel_weight;
        r_s1_mode <= acc_mode_e'(acc_mode_i);
      end
    end
  end

  fixed_point_mult #(
    .A_WIDTH (INPUT_WIDTH),
    .B_WIDTH (WEIGHT_WIDTH)
  ) u_mult (
    .i_a (r_s1_if),
    .i_b (r_s1_w),
    .o_p (w_prod)
  );

  always_comb begin
    w_addend = '0;
    if (r_s1_mode == ACC_LOCAL) begin
      w_addend = r_psum;
    end else if (psum_i_valid) begin
      w_addend = psum_i_data;
    end
  end

  // Product fraction = input frac + weight frac = psum frac, so no realignment.
  assign w_addend_ext = {{(SUM_MAX_W-PSUM_WIDTH){w_addend[PSUM_WIDTH-1]}}, w_addend};
  assign w_prod_ext   = {{(SUM_MAX_W-PW){w_prod[PW-1]}}, w_prod};
  assign w_add_res    = sat_add(w_addend_ext, w_prod_ext, PSUM_WIDTH, (SATURATE != 0));
  assign {w_ovf, w_unused_hi, w_sum} = w_add_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum_valid <= 1'b0;
      r_psum       <= '0;
      r_ovf        <= 1'b0;
    end else if (iclr) begin
      r_psum_valid <= 1'b0;
      r_psum       <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_psum_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_psum <= w_sum;
        if (w_ovf) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign iload_o_valid = r_s1_valid;
  assign if_o_data     = r_s1_if;
  assign wload_o_valid = r_wfwd_valid;
  assign wload_o_addr  = r_wfwd_addr;
  assign weight_o_data = r_wfwd_data;
  assign psum_o_valid  = r_psum_valid;
  assign psum_o_data   = r_psum;
  assign ovf_o         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ws_pe_dbuf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ws_pe_dbuf : directed + random bench, two PE configurations vs model  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_ws_pe_dbuf;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iclr, wclr, wload, wswap, mode, iload, psum_v;
  logic [2:0]  waddr, wsel;
  logic [7:0]  wdata;
  logic [15:0] ifd;
  logic [23:0] psum_in;

  // Instance A: 8 slots, saturating.  Instance B: 1 slot, wrapping.
  logic        iov_a, wv_a, pv_a, ovf_a, iov_b, wv_b, pv_b, ovf_b;
  logic [15:0] if_a, if_b;
  logic [2:0]  wa_a;
  logic [0:0]  wa_b;
  logic [7:0]  wd_a, wd_b;
  logic [23:0] pd_a, pd_b;

  ws_pe_dbuf #(.NUM_W(8), .SATURATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .iclr(iclr), .wclr(wclr),
    .wload_i_valid(wload), .wload_i_addr(waddr), .weight_i_data(wdata),
    .wswap_i(wswap), .wsel_i(wsel), .acc_mode_i(mode),
    .iload_i_valid(iload), .if_i_data(ifd),
    .psum_i_valid(psum_v), .psum_i_data(psum_in),
    .iload_o_valid(iov_a), .if_o_data(if_a),
    .wload_o_valid(wv_a), .wload_o_addr(wa_a), .weight_o_data(wd_a),
    .psum_o_valid(pv_a), .psum_o_data(pd_a), .ovf_o(ovf_a)
  );

  ws_pe_dbuf #(.NUM_W(1), .SATURATE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .iclr(iclr), .wclr(wclr),
    .wload_i_valid(wload), .wload_i_addr(waddr[0:0]), .weight_i_data(wdata),
    .wswap_i(wswap), .wsel_i(wsel[0:0]), .acc_mode_i(mode),
    .iload_i_valid(iload), .if_i_data(ifd),
    .psum_i_valid(psum_v), .psum_i_data(psum_in),
    .iload_o_valid(iov_b), .if_o_data(if_b),
    .wload_o_valid(wv_b), .wload_o_addr(wa_b), .weight_o_data(wd_b),
    .psum_o_valid(pv_b), .psum_o_data(pd_b), .ovf_o(ovf_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: banks as arrays, one op pending between issue and result.
  int unsigned NW   [2] = '{8, 1};
  bit          SATM [2] = '{1'b1, 1'b0};
  logic [7:0]  m_sh [2][8];
  logic [7:0]  m_ac [2][8];
  longint      m_psum [2];
  bit          m_ovf  [2];
  bit          e_pv   [2];
  bit          p_v, p_mode;
  logic [15:0] p_if;
  logic [7:0]  p_w [2];
  bit          e_iov, e_wv;
  logic [15:0] e_if;
  logic [2:0]  e_wa;
  logic [7:0]  e_wd;

  function automatic longint sx(input logic [63:0] v, input int w);
    longint r;
    r = longint'(v & ((64'd1 << w) - 64'd1));
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  task automatic clear_inputs();
    iclr = 0; wclr = 0; wload = 0; wswap = 0; mode = 0; iload = 0; psum_v = 0;
    waddr = 0; wsel = 0; wdata = 0; ifd = 0; psum_in = 0;
  endtask

  task automatic step();
    int unsigned addr [2];
    int unsigned sel  [2];
    longint prod, add, s, lim;
    addr[0] = waddr; addr[1] = waddr[0];
    sel[0]  = wsel;  sel[1]  = wsel[0];
    lim = longint'(1) << 23;
    for (int d = 0; d < 2; d++) begin
      e_pv[d] = 0;
      if (iclr) begin
        m_psum[d] = 0;
        m_ovf[d]  = 0;
      end else if (p_v) begin
        prod = sx(64'(p_if), 16) * sx(64'(p_w[d]), 8);
        add  = p_mode ? m_psum[d] : (psum_v ? sx(64'(psum_in), 24) : 0);
        s    = add + prod;
        if (s >= lim || s < -lim) begin
          m_ovf[d] = 1;
          if (SATM[d]) s = (s >= lim) ? lim - 1 : -lim;
          else         s = sx(64'(s), 24);
        end
        m_psum[d] = s;
        e_pv[d]   = 1;
      end
    end
    if (iclr) begin
      p_v = 0; e_iov = 0; e_if = 0;
    end else begin
      p_v = iload; e_iov = iload;
      if (iload) begin
        p_if = ifd; e_if = ifd; p_mode = mode;
        for (int d = 0; d < 2; d++) p_w[d] = (sel[d] < NW[d]) ? m_ac[d][sel[d]] : 8'h00;
      end
    end
    if (wclr) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 8; k++) begin m_sh[d][k] = 0; m_ac[d][k] = 0; end
      e_wv = 0; e_wa = 0; e_wd = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (wswap) m_ac[d] = m_sh[d];
        if (wload && addr[d] < NW[d]) m_sh[d][addr[d]] = wdata;
      end
      e_wv = wload; e_wa = waddr; e_wd = wdata;
    end
    @(posedge clk);
    #1;
    check_val("a_psum_valid", 64'(pv_a), 64'(e_pv[0]));
    check_val("a_psum_data",  64'(pd_a), 64'(m_psum[0][23:0]));
    check_val("a_ovf",        64'(ovf_a), 64'(m_ovf[0]));
    check_val("a_iload_o",    64'(iov_a), 64'(e_iov));
    check_val("a_if_o",       64'(if_a), 64'(e_if));
    check_val("a_wload_o",    64'(wv_a), 64'(e_wv));
    check_val("a_waddr_o",    64'(wa_a), 64'(e_wa));
    check_val("a_wdata_o",    64'(wd_a), 64'(e_wd));
    check_val("b_psum_valid", 64'(pv_b), 64'(e_pv[1]));
    check_val("b_psum_data",  64'(pd_b), 64'(m_psum[1][23:0]));
    check_val("b_ovf",        64'(ovf_b), 64'(m_ovf[1]));
    check_val("b_iload_o",    64'(iov_b), 64'(e_iov));
    check_val("b_if_o",       64'(if_b), 64'(e_if));
    check_val("b_wload_o",    64'(wv_b), 64'(e_wv));
    check_val("b_waddr_o",    64'(wa_b), 64'(e_wa[0]));
    check_val("b_wdata_o",    64'(wd_b), 64'(e_wd));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin m_sh[d][k] = 0; m_ac[d][k] = 0; end
      m_psum[d] = 0; m_ovf[d] = 0; e_pv[d] = 0; p_w[d] = 0;
    end
    p_v = 0; p_mode = 0; p_if = 0; e_iov = 0; e_if = 0; e_wv = 0; e_wa = 0; e_wd = 0;
    clear_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_psum_a",  64'(pd_a), 64'h0);
    check_val("rst_pvalid_a", 64'(pv_a), 64'h0);
    check_val("rst_ovf_a",   64'(ovf_a), 64'h0);
    check_val("rst_if_o_a",  64'(if_a), 64'h0);
    check_val("rst_wv_b",    64'(wv_b), 64'h0);
    rst_n = 1;

    // Basic chain op
    clear_inputs(); wload = 1; waddr = 0; wdata = 8'h20; step();
    clear_inputs(); wswap = 1; step();
    clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 0; step();
    check_val("basic_iload_o", 64'(iov_a), 64'h1);
    check_val("basic_if_o", 64'(if_a), 64'h0100);
    clear_inputs(); psum_v = 1; psum_in = 24'h004000; step();
    check_val("basic_valid", 64'(pv_a), 64'h1);
    check_val("basic_psum", 64'(pd_a), 64'h006000);
    clear_inputs(); step();
    check_val("basic_pulse", 64'(pv_a), 64'h0);
    check_val("basic_hold", 64'(pd_a), 64'h006000);

    // Swap hazard
    clear_inputs(); wload = 1; waddr = 2; wdata = 8'h20; step();
    clear_inputs(); wswap = 1; step();
    clear_inputs(); wload = 1; waddr = 2; wdata = 8'h40; step();
    clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 2; wswap = 1; step();
    clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 2; step();
    check_val("hazard_pre_swap", 64'(pd_a), 64'h002000);
    clear_inputs(); step();
    check_val("hazard_post_swap", 64'(pd_a), 64'h004000);
    clear_inputs(); wload = 1; waddr = 2; wdata = 8'h10; wswap = 1; step();
    clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 2; step();
    clear_inputs(); step();
    check_val("same_cycle_active", 64'(pd_a), 64'h004000);
    clear_inputs(); wswap = 1; step();
    clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 2; step();
    clear_inputs(); step();
    check_val("same_cycle_shadow", 64'(pd_a), 64'h001000);

    // Local accumulate
    clear_inputs(); iclr = 1; wload = 1; waddr = 1; wdata = 8'h40; step();
    clear_inputs(); wswap = 1; step();
    for (int k = 0; k < 4; k++) begin
      clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 1; mode = 1; step();
      if (k > 0) check_val("local_acc", 64'(pd_a), 64'(k * 24'h004000));
    end
    clear_inputs(); step();
    check_val("local_acc_last", 64'(pd_a), 64'h010000);

    // Saturation / wrap
    clear_inputs(); iclr = 1; wload = 1; waddr = 0; wdata = 8'h7F; step();
    clear_inputs(); wswap = 1; step();
    clear_inputs(); iload = 1; ifd = 16'h7FFF; wsel = 0; step();
    clear_inputs(); psum_v = 1; psum_in = 24'h7FFFFF; step();
    check_val("sat_psum_a", 64'(pd_a), 64'h7FFFFF);
    check_val("sat_ovf_a", 64'(ovf_a), 64'h1);
    check_val("wrap_psum_b", 64'(pd_b), 64'hBF7F80);
    check_val("wrap_ovf_b", 64'(ovf_b), 64'h1);
    clear_inputs(); repeat (3) step();
    check_val("ovf_sticky", 64'(ovf_a), 64'h1);

    // iclr mid-flight
    clear_inputs(); iload = 1; ifd = 16'h0100; wsel = 0; step();
    clear_inputs(); iclr = 1; psum_v = 1; psum_in = 24'h000100; step();
    check_val("iclr_valid", 64'(pv_a), 64'h0);
    check_val("iclr_psum", 64'(pd_a), 64'h0);
    check_val("iclr_ovf", 64'(ovf_a), 64'h0);
    clear_inputs(); step();
    check_val("iclr_dropped", 64'(pv_a), 64'h0);

    // Concurrent iclr + wclr
    clear_inputs(); iclr = 1; wclr = 1; step();
    clear_inputs(); iload = 1; ifd = 16'h1234; wsel = 0; step();
    clear_inputs(); psum_v = 1; psum_in = 24'h0; step();
    check_val("wclr_valid", 64'(pv_a), 64'h1);
    check_val("wclr_psum", 64'(pd_a), 64'h0);

    // Weight chain forward (slot 3 is out of range for instance B)
    clear_inputs(); wload = 1; waddr = 3; wdata = 8'h55; step();
    check_val("fwd_valid", 64'(wv_a), 64'h1);
    check_val("fwd_addr", 64'(wa_a), 64'h3);
    check_val("fwd_data", 64'(wd_a), 64'h55);
    check_val("fwd_addr_b", 64'(wa_b), 64'h1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      iclr    = ($urandom_range(0, 99) < 2);
      wclr    = ($urandom_range(0, 99) < 2);
      wload   = $urandom_range(0, 1);
      waddr   = 3'($urandom);
      wdata   = 8'($urandom);
      wswap   = ($urandom_range(0, 99) < 15);
      iload   = ($urandom_range(0, 99) < 70);
      mode    = ($urandom_range(0, 99) < 30);
      wsel    = 3'($urandom);
      ifd     = 16'($urandom);
      psum_v  = ($urandom_range(0, 99) < 70);
      psum_in = 24'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
